// File: rtl/trap_unit_multi.sv
`default_nettype none
// ============================================================================
// Module  : trap_unit_multi
// Brief   : Prioritised exception/trap sequencer with uepc/ucause/utval and uret
// Revision: 1.0 - initial release
// ============================================================================
module trap_unit_multi #(
    parameter int              XLEN        = 32,
    parameter int              NSRC        = 7,
    parameter logic [XLEN-1:0] TEXT_BASE   = 32'h0040_0000,
    parameter logic [XLEN-1:0] TEXT_END    = 32'h0040_0FFC,
    parameter bit              DOUBLE_HALT = 1'b1
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic [XLEN-1:0] iPC,
    input  logic            iFetchCheck,
    input  logic [NSRC-1:0] iExcReq,
    input  logic [XLEN-1:0] iExcTval,
    input  logic            iUret,
    input  logic [XLEN-1:0] iUtvec,
    input  logic            iCsrWe,
    input  logic [11:0]     iCsrAddr,
    input  logic [XLEN-1:0] iCsrWData,
    output logic [XLEN-1:0] oCsrRData,
    output logic            oTrapTake,
    output logic [XLEN-1:0] oTargetPC,
    output logic            oBusy,
    output logic            oInHandler,
    output logic            oDoubleFault,
    output logic [XLEN-1:0] oUepc,
    output logic [XLEN-1:0] oUcause,
    output logic [XLEN-1:0] oUtval
);

    localparam logic [11:0] c_ADDR_UEPC   = 12'h041;
    localparam logic [11:0] c_ADDR_UCAUSE = 12'h042;
    localparam logic [11:0] c_ADDR_UTVAL  = 12'h043;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [XLEN-1:0] r_uepc;
    logic [XLEN-1:0] r_ucause;
    logic [XLEN-1:0] r_utval;
    logic [XLEN-1:0] r_target;
    logic            r_inHandler;
    logic            r_doubleFault;

    logic            w_fetchMis;
    logic            w_fetchRange;
    logic            w_fetchFault;
    logic            w_extAny;
    logic [XLEN-1:0] w_extCause;
    logic [XLEN-1:0] w_cause;
    logic            w_trap;
    logic [XLEN-1:0] w_trapTval;
    logic [XLEN-1:0] w_vecBase;
    logic [XLEN-1:0] w_trapTarget;

    assign w_fetchMis   = iFetchCheck && (iPC[1:0] != 2'b00);
    assign w_fetchRange = iFetchCheck && ((iPC < TEXT_BASE) || (iPC > TEXT_END));
    assign w_fetchFault = w_fetchMis || w_fetchRange;
    assign w_extAny     = |iExcReq;

    // Scan from lowest priority up so the lowest set index is the survivor.
    always_comb begin
        w_extCause = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (iExcReq[k]) begin
                w_extCause = XLEN'(k) + XLEN'(2);
            end
        end
    end

    always_comb begin
        w_cause = w_extCause;
        if (w_fetchMis) begin
            w_cause = '0;
        end else if (w_fetchRange) begin
            w_cause = XLEN'(1);
        end
    end

    assign w_trap       = (r_state == S_IDLE) && (w_fetchFault || w_extAny);
    assign w_trapTval   = w_fetchFault ? iPC : iExcTval;
    assign w_vecBase    = iUtvec & ~XLEN'(3);
    assign w_trapTarget = w_vecBase + (iUtvec[0] ? (w_cause << 2) : '0);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trap) begin
                    w_nextState = (DOUBLE_HALT && r_inHandler) ? S_HALT : S_REDIRECT;
                end else if (iUret) begin
                    w_nextState = S_REDIRECT;
                end
            end
            S_REDIRECT: w_nextState = S_IDLE;
            S_HALT:     w_nextState = S_HALT;
            default:    w_nextState = S_IDLE;
        endcase
    end

    // Trap capture takes precedence over any CSR write landing in the same cycle.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_uepc        <= '0;
            r_ucause      <= '0;
            r_utval       <= '0;
            r_target      <= '0;
            r_inHandler   <= 1'b0;
            r_doubleFault <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_trap) begin
                r_uepc      <= iPC;
                r_ucause    <= w_cause;
                r_utval     <= w_trapTval;
                r_target    <= w_trapTarget;
                r_inHandler <= 1'b1;
                if (r_inHandler) begin
                    r_doubleFault <= 1'b1;
                end
            end else begin
                if (iUret) begin
                    r_target    <= r_uepc;
                    r_inHandler <= 1'b0;
                end
                if (iCsrWe) begin
                    case (iCsrAddr)
                        c_ADDR_UEPC:   r_uepc   <= iCsrWData;
                        c_ADDR_UCAUSE: r_ucause <= iCsrWData;
                        c_ADDR_UTVAL:  r_utval  <= iCsrWData;
                        default:       ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        oCsrRData = '0;
        case (iCsrAddr)
            c_ADDR_UEPC:   oCsrRData = r_uepc;
            c_ADDR_UCAUSE: oCsrRData = r_ucause;
            c_ADDR_UTVAL:  oCsrRData = r_utval;
            default:       oCsrRData = '0;
        endcase
    end

    assign oTrapTake    = (r_state == S_REDIRECT);
    assign oBusy        = (r_state != S_IDLE);
    assign oTargetPC    = r_target;
    assign oInHandler   = r_inHandler;
    assign oDoubleFault = r_doubleFault;
    assign oUepc        = r_uepc;
    assign oUcause      = r_ucause;
    assign oUtval       = r_utval;

endmodule
`default_nettype wire

// File: tb/tb_trap_unit_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_trap_unit_multi
// Brief   : Directed self-checking bench for trap_unit_multi (both DOUBLE_HALT modes)
// Revision: 1.0 - initial release
// ============================================================================
module tb_trap_unit_multi;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [31:0] iPC = '0;
    logic        iFetchCheck = 1'b0;
    logic [6:0]  iExcReq = '0;
    logic [31:0] iExcTval = '0;
    logic        iUret = 1'b0;
    logic [31:0] iUtvec = '0;
    logic        iCsrWe = 1'b0;
    logic [11:0] iCsrAddr = '0;
    logic [31:0] iCsrWData = '0;

    logic [31:0] hCsrRData, hTargetPC, hUepc, hUcause, hUtval;
    logic        hTrapTake, hBusy, hInHandler, hDoubleFault;
    logic [31:0] nCsrRData, nTargetPC, nUepc, nUcause, nUtval;
    logic        nTrapTake, nBusy, nInHandler, nDoubleFault;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 iCLK = ~iCLK;

    trap_unit_multi #(.DOUBLE_HALT(1'b1)) dut (
        .iCLK(iCLK), .iRST(iRST), .iPC(iPC), .iFetchCheck(iFetchCheck),
        .iExcReq(iExcReq), .iExcTval(iExcTval), .iUret(iUret), .iUtvec(iUtvec),
        .iCsrWe(iCsrWe), .iCsrAddr(iCsrAddr), .iCsrWData(iCsrWData),
        .oCsrRData(hCsrRData), .oTrapTake(hTrapTake), .oTargetPC(hTargetPC),
        .oBusy(hBusy), .oInHandler(hInHandler), .oDoubleFault(hDoubleFault),
        .oUepc(hUepc), .oUcause(hUcause), .oUtval(hUtval)
    );

    trap_unit_multi #(.DOUBLE_HALT(1'b0)) dutNoHalt (
        .iCLK(iCLK), .iRST(iRST), .iPC(iPC), .iFetchCheck(iFetchCheck),
        .iExcReq(iExcReq), .iExcTval(iExcTval), .iUret(iUret), .iUtvec(iUtvec),
        .iCsrWe(iCsrWe), .iCsrAddr(iCsrAddr), .iCsrWData(iCsrWData),
        .oCsrRData(nCsrRData), .oTrapTake(nTrapTake), .oTargetPC(nTargetPC),
        .oBusy(nBusy), .oInHandler(nInHandler), .oDoubleFault(nDoubleFault),
        .oUepc(nUepc), .oUcause(nUcause), .oUtval(nUtval)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic clearIn();
        iFetchCheck = 1'b0;
        iExcReq     = '0;
        iExcTval    = '0;
        iUret       = 1'b0;
        iCsrWe      = 1'b0;
        iCsrAddr    = '0;
        iCsrWData   = '0;
    endtask

    initial begin
        tick();
        tick();
        iRST = 1'b0;
        checkVal("rst_take",   32'(hTrapTake),    32'd0);
        checkVal("rst_busy",   32'(hBusy),        32'd0);
        checkVal("rst_inh",    32'(hInHandler),   32'd0);
        checkVal("rst_df",     32'(hDoubleFault), 32'd0);
        checkVal("rst_uepc",   hUepc,             32'd0);
        checkVal("rst_ucause", hUcause,           32'd0);
        checkVal("rst_utval",  hUtval,            32'd0);
        checkVal("rst_target", hTargetPC,         32'd0);

        // Misaligned fetch, direct-mode vector
        iUtvec = 32'h0040_0100; iPC = 32'h0040_0002; iFetchCheck = 1'b1;
        tick(); clearIn();
        checkVal("mis_take",   32'(hTrapTake),  32'd1);
        checkVal("mis_busy",   32'(hBusy),      32'd1);
        checkVal("mis_cause",  hUcause,         32'd0);
        checkVal("mis_tval",   hUtval,          32'h0040_0002);
        checkVal("mis_epc",    hUepc,           32'h0040_0002);
        checkVal("mis_target", hTargetPC,       32'h0040_0100);
        checkVal("mis_inh",    32'(hInHandler), 32'd1);
        tick();
        checkVal("mis_take2",  32'(hTrapTake),  32'd0);
        checkVal("mis_busy2",  32'(hBusy),      32'd0);

        // CSR write of uepc, then uret back to it
        iCsrWe = 1'b1; iCsrAddr = 12'h041; iCsrWData = 32'h0040_0020;
        tick(); clearIn();
        iCsrAddr = 12'h041;
        #1 checkVal("rd_uepc", hCsrRData, 32'h0040_0020);
        iCsrAddr = 12'h040;
        #1 checkVal("rd_other", hCsrRData, 32'd0);
        iUret = 1'b1;
        tick(); clearIn();
        checkVal("ret_take",   32'(hTrapTake),  32'd1);
        checkVal("ret_target", hTargetPC,       32'h0040_0020);
        checkVal("ret_inh",    32'(hInHandler), 32'd0);
        tick();

        // External priority, vectored mode
        iUtvec = 32'h0040_0101; iPC = 32'h0040_0040;
        iExcReq = 7'b0010100; iExcTval = 32'h1001_0003;
        tick(); clearIn();
        checkVal("ext_take",   32'(hTrapTake), 32'd1);
        checkVal("ext_cause",  hUcause,        32'd4);
        checkVal("ext_tval",   hUtval,         32'h1001_0003);
        checkVal("ext_epc",    hUepc,          32'h0040_0040);
        checkVal("ext_target", hTargetPC,      32'h0040_0110);

        // Reset in the middle of REDIRECT
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        checkVal("midrst_take",  32'(hTrapTake),  32'd0);
        checkVal("midrst_busy",  32'(hBusy),      32'd0);
        checkVal("midrst_cause", hUcause,         32'd0);
        checkVal("midrst_tval",  hUtval,          32'd0);
        checkVal("midrst_epc",   hUepc,           32'd0);
        checkVal("midrst_inh",   32'(hInHandler), 32'd0);

        // Out-of-range fetch outranks external request
        iUtvec = 32'h0040_0100; iPC = 32'h0000_1000; iFetchCheck = 1'b1;
        iExcReq = 7'b0000001; iExcTval = 32'h0000_DEAD;
        tick(); clearIn();
        checkVal("rng_cause",  hUcause,   32'd1);
        checkVal("rng_tval",   hUtval,    32'h0000_1000);
        checkVal("rng_target", hTargetPC, 32'h0040_0100);
        tick();
        iUret = 1'b1;
        tick(); clearIn();
        checkVal("rng_ret", hTargetPC, 32'h0000_1000);
        tick();

        // CSR write to ucause concurrent with a trap: trap wins
        iPC = 32'h0040_0080; iExcReq = 7'b0000010; iExcTval = 32'h0000_0077;
        iCsrWe = 1'b1; iCsrAddr = 12'h042; iCsrWData = 32'h0000_0055;
        tick(); clearIn();
        checkVal("csrtrap_cause", hUcause, 32'd3);
        checkVal("csrtrap_tval",  hUtval,  32'h0000_0077);
        tick();
        iUret = 1'b1;
        tick(); clearIn();
        checkVal("csrtrap_ret", hTargetPC, 32'h0040_0080);
        tick();

        // uret with ecall in the same cycle: exception wins
        iUret = 1'b1; iExcReq = 7'b1000000; iPC = 32'h0040_0090;
        tick(); clearIn();
        checkVal("ecall_take",   32'(hTrapTake),  32'd1);
        checkVal("ecall_cause",  hUcause,         32'd8);
        checkVal("ecall_target", hTargetPC,       32'h0040_0100);
        checkVal("ecall_inh",    32'(hInHandler), 32'd1);
        tick();

        // Second trap while in the handler
        iExcReq = 7'b0001000; iPC = 32'h0040_00A0; iExcTval = 32'h0000_0011;
        tick(); clearIn();
        checkVal("dh_take",    32'(hTrapTake),    32'd0);
        checkVal("dh_busy",    32'(hBusy),        32'd1);
        checkVal("dh_df",      32'(hDoubleFault), 32'd1);
        checkVal("dn_take",    32'(nTrapTake),    32'd1);
        checkVal("dn_df",      32'(nDoubleFault), 32'd1);
        checkVal("dn_cause",   nUcause,           32'd5);
        for (int i = 0; i < 4; i++) begin
            iExcReq = 7'b0000001; iUret = 1'b1;
            tick();
        end
        clearIn();
        checkVal("dh_take_stuck", 32'(hTrapTake), 32'd0);
        checkVal("dh_busy_stuck", 32'(hBusy),     32'd1);
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        checkVal("dh_rst_busy", 32'(hBusy),        32'd0);
        checkVal("dh_rst_df",   32'(hDoubleFault), 32'd0);
        checkVal("dn_rst_df",   32'(nDoubleFault), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
